// File: rtl/biu_constants_pkg.sv
// Shared bus-interface constants used by the core and its memories.
package biu_constants_pkg;

    // Access size as issued by the core.
    typedef enum logic [1:0] {
        BYTE  = 2'b00,
        HWORD = 2'b01,
        WORD  = 2'b10,
        DWORD = 2'b11
    } biu_size_t;

endpackage

// File: rtl/riscv_dtcm_ram.sv
// Single-port synchronous RAM with per-byte write enables and a 1-cycle read.
module riscv_dtcm_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Write enabled lanes, or register the addressed word for a read; no reset on storage.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/riscv_dtcm.sv
// Data tightly-coupled memory: fixed 1-cycle latency, alignment and range checking.
module riscv_dtcm
    import biu_constants_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     DEPTH     = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            dmem_req,
    input  logic [XLEN-1:0] dmem_adr,
    input  logic [XLEN-1:0] dmem_d,
    input  logic            dmem_we,
    input  biu_size_t       dmem_size,
    output logic [XLEN-1:0] dmem_q,
    output logic            dmem_ack,
    output logic            dmem_err,
    output logic            dmem_misaligned,
    output logic            dmem_page_fault
);

    localparam int unsigned     AW   = $clog2(DEPTH);
    localparam logic [XLEN-1:0] SPAN = XLEN'(DEPTH * 4);

    logic [XLEN-1:0] offset;
    logic            misaligned;
    logic            out_of_range;
    logic            bad_access;
    logic            valid;
    logic [3:0]      be;
    logic            ram_en;
    logic [AW-1:0]   ram_addr;
    logic [31:0]     ram_rdata;

    logic            ack_q;
    logic            err_q;
    logic            mis_q;
    logic            rd_q;

    // Decode: alignment, range, byte enables and the RAM word index.
    always_comb begin
        offset       = dmem_adr - BASE_ADDR;
        // Addresses below BASE_ADDR wrap to large offsets and fail the range check too.
        out_of_range = (offset >= SPAN);
        misaligned   = 1'b0;
        be           = 4'b0000;
        case (dmem_size)
            BYTE: begin
                be[dmem_adr[1:0]] = 1'b1;
            end
            HWORD: begin
                misaligned = dmem_adr[0];
                be         = dmem_adr[1] ? 4'b1100 : 4'b0011;
            end
            WORD: begin
                misaligned = (dmem_adr[1:0] != 2'b00);
                be         = 4'b1111;
            end
            default: begin
                be = 4'b0000;
            end
        endcase
        // Misalignment wins over error.
        bad_access = !misaligned && (out_of_range || (dmem_size == DWORD));
        valid      = dmem_req && !misaligned && !bad_access;
        // Requests seen while reset is held must not touch memory.
        ram_en     = valid && rstn;
        ram_addr   = offset[AW+1:2];
    end

    riscv_dtcm_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (dmem_we),
        .be    (be),
        .addr  (ram_addr),
        .wdata (dmem_d[31:0]),
        .rdata (ram_rdata)
    );

    // Response registers: exactly one of ack/err/misaligned per sampled request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            mis_q <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            ack_q <= valid;
            err_q <= dmem_req && bad_access;
            mis_q <= dmem_req && misaligned;
            rd_q  <= valid && !dmem_we;
        end
    end

    // Read data is only presented in a read-ack cycle; reset clears it via ack_q.
    always_comb begin
        dmem_q          = (ack_q && rd_q) ? XLEN'(ram_rdata) : '0;
        dmem_ack        = ack_q;
        dmem_err        = err_q;
        dmem_misaligned = mis_q;
        dmem_page_fault = 1'b0;
    end

endmodule

// File: tb/tb_riscv_dtcm.sv
// Self-checking bench for riscv_dtcm using a per-cycle response scoreboard.
module tb_riscv_dtcm;
    import biu_constants_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        mis;
        logic [31:0] q;
    } resp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        dmem_req = 1'b0;
    logic [31:0] dmem_adr = '0;
    logic [31:0] dmem_d = '0;
    logic        dmem_we = 1'b0;
    biu_size_t   dmem_size = WORD;
    logic [31:0] dmem_q;
    logic        dmem_ack;
    logic        dmem_err;
    logic        dmem_misaligned;
    logic        dmem_page_fault;

    int          n_checks = 0;
    int          n_fail = 0;
    resp_t       exp_q[$];
    logic [31:0] mdl [DEPTH];

    riscv_dtcm #(
        .XLEN      (32),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .dmem_req        (dmem_req),
        .dmem_adr        (dmem_adr),
        .dmem_d          (dmem_d),
        .dmem_we         (dmem_we),
        .dmem_size       (dmem_size),
        .dmem_q          (dmem_q),
        .dmem_ack        (dmem_ack),
        .dmem_err        (dmem_err),
        .dmem_misaligned (dmem_misaligned),
        .dmem_page_fault (dmem_page_fault)
    );

    always #5 clk = ~clk;

    // Reference model: returns the expected response and updates model memory.
    function automatic resp_t model(input logic req, input logic we, input logic [31:0] adr,
                                    input logic [31:0] d, input biu_size_t size);
        resp_t       r;
        logic        mis;
        logic        err;
        logic [31:0] off;
        int          idx;
        r   = '0;
        if (!req) return r;
        mis = (size == HWORD && adr[0]) || (size == WORD && adr[1:0] != 2'b00);
        off = adr - BASE;
        err = !mis && ((off >= DEPTH * 4) || size == DWORD);
        idx = int'(off >> 2);
        if (mis) begin
            r.mis = 1'b1;
        end else if (err) begin
            r.err = 1'b1;
        end else begin
            r.ack = 1'b1;
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (size == WORD || (size == BYTE && i == int'(adr[1:0])) ||
                        (size == HWORD && (i / 2) == int'(adr[1]))) begin
                        mdl[idx][8*i +: 8] = d[8*i +: 8];
                    end
                end
            end else begin
                r.q = mdl[idx];
            end
        end
        return r;
    endfunction

    // Drive one cycle (called just after a negedge), push expectation, check after the edge.
    task automatic cycle(input logic req, input logic we, input logic [31:0] adr,
                         input logic [31:0] d, input biu_size_t size);
        resp_t e;
        dmem_req  = req;
        dmem_we   = we;
        dmem_adr  = adr;
        dmem_d    = d;
        dmem_size = size;
        exp_q.push_back(model(req, we, adr, d, size));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_checks += 4;
        if (dmem_ack !== e.ack) begin
            n_fail++;
            $display("FAIL ack adr=%h: got %b want %b", adr, dmem_ack, e.ack);
        end
        if (dmem_err !== e.err) begin
            n_fail++;
            $display("FAIL err adr=%h: got %b want %b", adr, dmem_err, e.err);
        end
        if (dmem_misaligned !== e.mis) begin
            n_fail++;
            $display("FAIL misaligned adr=%h: got %b want %b", adr, dmem_misaligned, e.mis);
        end
        if (dmem_q !== e.q) begin
            n_fail++;
            $display("FAIL q adr=%h: got %h want %h", adr, dmem_q, e.q);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 32'h0, WORD);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        dmem_req = 1'b0;
        repeat (2) @(negedge clk);
        n_checks += 2;
        if ({dmem_ack, dmem_err, dmem_misaligned} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000", {dmem_ack, dmem_err, dmem_misaligned});
        end
        if (dmem_q !== 32'h0 || dmem_page_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_q: got q=%h pf=%b want 0/0", dmem_q, dmem_page_fault);
        end
        rstn = 1'b1;
        idle();
    endtask

    task automatic test_word_rw();
        cycle(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, WORD);
        cycle(1'b1, 1'b0, 32'h10, 32'h0, WORD);
        idle();
    endtask

    task automatic test_byte_lanes();
        cycle(1'b1, 1'b1, 32'h10, 32'h11223344, WORD);
        cycle(1'b1, 1'b1, 32'h11, 32'h0000AA00, BYTE);
        cycle(1'b1, 1'b0, 32'h10, 32'h0, WORD);
        cycle(1'b1, 1'b1, 32'h12, 32'h55660000, HWORD);
        cycle(1'b1, 1'b1, 32'h13, 32'h77000000, BYTE);
        cycle(1'b1, 1'b0, 32'h10, 32'h0, WORD);
        cycle(1'b1, 1'b0, 32'h12, 32'h0, HWORD);
        idle();
    endtask

    task automatic test_misaligned();
        cycle(1'b1, 1'b0, 32'h13, 32'h0, HWORD);
        cycle(1'b1, 1'b1, 32'h12, 32'hCAFEF00D, WORD);
        cycle(1'b1, 1'b1, 32'h11, 32'hCAFEF00D, HWORD);
        cycle(1'b1, 1'b0, 32'h10, 32'h0, WORD);
        idle();
    endtask

    task automatic test_errors();
        cycle(1'b1, 1'b1, 32'h4, 32'h0BADC0DE, WORD);
        cycle(1'b1, 1'b0, BASE + DEPTH * 4, 32'h0, WORD);
        cycle(1'b1, 1'b0, 32'h0, 32'h0, DWORD);
        // Out-of-range write would alias onto word 1 if the range check were missing.
        cycle(1'b1, 1'b1, BASE + DEPTH * 4 + 4, 32'hFFFFFFFF, WORD);
        cycle(1'b1, 1'b1, 32'h5, 32'h0, DWORD);
        cycle(1'b1, 1'b0, 32'h4, 32'h0, WORD);
        cycle(1'b1, 1'b0, BASE + DEPTH * 4 - 4, 32'h0, BYTE);
        idle();
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 1'b1, 32'h0, 32'hA0A0A0A0, WORD);
        cycle(1'b1, 1'b1, 32'h4, 32'hB1B1B1B1, WORD);
        cycle(1'b1, 1'b1, 32'h8, 32'hC2C2C2C2, WORD);
        cycle(1'b1, 1'b0, 32'h0, 32'h0, WORD);
        cycle(1'b1, 1'b0, 32'h4, 32'h0, WORD);
        cycle(1'b1, 1'b0, 32'h8, 32'h0, WORD);
        // Write immediately followed by a read of the same word.
        cycle(1'b1, 1'b1, 32'h8, 32'h12345678, WORD);
        cycle(1'b1, 1'b0, 32'h8, 32'h0, WORD);
        idle();
    endtask

    task automatic test_reset_mid();
        resp_t e;
        cycle(1'b1, 1'b1, 32'h20, 32'h600DF00D, WORD);
        // Read sampled at the next edge, then reset asserted mid-cycle.
        dmem_req  = 1'b1;
        dmem_we   = 1'b0;
        dmem_adr  = 32'h20;
        dmem_size = WORD;
        e = model(1'b1, 1'b0, 32'h20, 32'h0, WORD);
        @(posedge clk);
        #1;
        n_checks++;
        if (dmem_ack !== e.ack || dmem_q !== e.q) begin
            n_fail++;
            $display("FAIL pre_reset_read: got ack=%b q=%h want %b/%h", dmem_ack, dmem_q, e.ack, e.q);
        end
        #1;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (dmem_ack !== 1'b0 || dmem_q !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: got ack=%b q=%h want 0/0", dmem_ack, dmem_q);
        end
        // A write presented during reset must be ignored.
        @(negedge clk);
        dmem_we = 1'b1;
        dmem_adr = 32'h20;
        dmem_d = 32'hFFFF0000;
        @(posedge clk);
        #1;
        n_checks++;
        if (dmem_ack !== 1'b0 || dmem_err !== 1'b0 || dmem_misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL in_reset_resp: got %b%b%b want 000", dmem_ack, dmem_err, dmem_misaligned);
        end
        @(negedge clk);
        dmem_req = 1'b0;
        rstn = 1'b1;
        cycle(1'b1, 1'b0, 32'h20, 32'h0, WORD);
        cycle(1'b1, 1'b0, 32'h8, 32'h0, WORD);
        idle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_misaligned();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
